// File: rtl/gfx_raster_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gfx_raster_sched_pkg
// Description : Shared types and constants for the raster command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package gfx_raster_sched_pkg;

    localparam int C_NUM_REQ     = 2;
    localparam int C_NUM_COORD   = 6;
    localparam int C_COORD_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_POINT = 3'd0,
        OP_LINE  = 3'd1,
        OP_RECT  = 3'd2,
        OP_TRI   = 3'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    typedef logic signed [C_COORD_W_DEF-1:0] coord_t;

    // Encodings 4-7 are reserved; only the low four are real primitives.
    function automatic logic op_is_valid(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage : gfx_raster_sched_pkg
`default_nettype wire

// File: rtl/gfx_raster_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : gfx_raster_sched_if
// Description : Requester-side command bus (valid/ready, opcode, coords, done).
// Revision    : 1.0 - initial release
// ============================================================================
interface gfx_raster_sched_if #(
    parameter int CW = 32
);
    import gfx_raster_sched_pkg::*;

    logic [C_NUM_REQ-1:0]                            req_valid;
    logic [C_NUM_REQ-1:0]                            req_ready;
    logic [C_NUM_REQ-1:0][2:0]                       req_op;
    logic [C_NUM_REQ-1:0][C_NUM_COORD-1:0][CW-1:0]   req_coord;
    logic [C_NUM_REQ-1:0]                            done;
    logic                                            err;

    modport master (
        output req_valid, req_op, req_coord,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_op, req_coord,
        output req_ready, done, err
    );

endinterface : gfx_raster_sched_if
`default_nettype wire

// File: rtl/gfx_raster_sched_arb.sv
`default_nettype none
// ============================================================================
// Module      : gfx_rr_arbiter2
// Description : Two-way round-robin arbiter, combinational grant, registered pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_rr_arbiter2 (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    input  wire logic       en_i,
    input  wire logic [1:0] req_i,
    output logic      [1:0] gnt_o,
    output logic            gnt_idx_o,
    output logic            gnt_valid_o
);

    // ptr_q names the port that wins a tie; 0 after reset.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o     = 2'b00;
        gnt_idx_o = 1'b0;
        if (en_i) begin
            case (req_i)
                2'b01:   begin gnt_o = 2'b01; gnt_idx_o = 1'b0; end
                2'b10:   begin gnt_o = 2'b10; gnt_idx_o = 1'b1; end
                2'b11:   begin
                    gnt_idx_o = ptr_q;
                    gnt_o     = ptr_q ? 2'b10 : 2'b01;
                end
                default: begin gnt_o = 2'b00; gnt_idx_o = 1'b0; end
            endcase
        end
        gnt_valid_o = |gnt_o;
        ptr_d       = gnt_valid_o ? ~gnt_idx_o : ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : gfx_rr_arbiter2
`default_nettype wire

// File: rtl/gfx_raster_sched.sv
`default_nettype none
// ============================================================================
// Module      : gfx_raster_sched
// Description : Arbitrates two command requesters onto the rasterizer strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_raster_sched
    import gfx_raster_sched_pkg::*;
#(
    parameter int POINT_WIDTH    = 16,
    parameter int SUBPIXEL_WIDTH = 16,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input  wire logic                                      clk_i,
    input  wire logic                                      rst_i,
    gfx_raster_sched_if.slave                              req_if,
    output logic                                           busy_o,
    output logic                                           point_write_o,
    output logic                                           rect_write_o,
    output logic                                           line_write_o,
    output logic                                           triangle_write_o,
    output logic signed [POINT_WIDTH+SUBPIXEL_WIDTH-1:0]   dest_pixel0_x_o,
    output logic signed [POINT_WIDTH+SUBPIXEL_WIDTH-1:0]   dest_pixel0_y_o,
    output logic signed [POINT_WIDTH+SUBPIXEL_WIDTH-1:0]   dest_pixel1_x_o,
    output logic signed [POINT_WIDTH+SUBPIXEL_WIDTH-1:0]   dest_pixel1_y_o,
    output logic signed [POINT_WIDTH+SUBPIXEL_WIDTH-1:0]   dest_pixel2_x_o,
    output logic signed [POINT_WIDTH+SUBPIXEL_WIDTH-1:0]   dest_pixel2_y_o,
    input  wire logic                                      raster_ack_i,
    output logic                                           timeout_o,
    input  wire logic                                      clr_timeout_i
);

    localparam int                       CW       = POINT_WIDTH + SUBPIXEL_WIDTH;
    localparam logic [TIMEOUT_WIDTH-1:0] C_WD_MAX = '1;

    state_e                              state_q, state_d;
    logic [2:0]                          op_q, op_d;
    logic                                owner_q, owner_d;
    logic                                inv_q, inv_d;
    logic [C_NUM_COORD-1:0][CW-1:0]      coord_q, coord_d;
    logic [TIMEOUT_WIDTH-1:0]            wd_q, wd_d;
    logic                                tout_q, tout_d;

    logic [1:0]                          w_gnt;
    logic                                w_gnt_idx;
    logic                                w_gnt_valid;
    logic [2:0]                          w_sel_op;
    logic [1:0]                          w_owner_oh;

    // Requester inputs are only looked at while idle and out of reset.
    gfx_rr_arbiter2 u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        ((state_q == ST_IDLE) && !rst_i),
        .req_i       (req_if.req_valid),
        .gnt_o       (w_gnt),
        .gnt_idx_o   (w_gnt_idx),
        .gnt_valid_o (w_gnt_valid)
    );

    assign w_sel_op   = req_if.req_op[w_gnt_idx];
    assign w_owner_oh = owner_q ? 2'b10 : 2'b01;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_gnt_valid) state_d = op_is_valid(w_sel_op) ? ST_SETUP : ST_GAP;
            ST_SETUP: state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (raster_ack_i) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        req_if.req_ready = w_gnt;
        req_if.done      = 2'b00;
        req_if.err       = 1'b0;
        point_write_o    = 1'b0;
        line_write_o     = 1'b0;
        rect_write_o     = 1'b0;
        triangle_write_o = 1'b0;
        busy_o           = (state_q != ST_IDLE);
        if (!rst_i) begin
            if (state_q == ST_ISSUE) begin
                case (op_q)
                    OP_POINT: point_write_o    = 1'b1;
                    OP_LINE:  line_write_o     = 1'b1;
                    OP_RECT:  rect_write_o     = 1'b1;
                    OP_TRI:   triangle_write_o = 1'b1;
                    default:  point_write_o    = 1'b0;
                endcase
            end
            if ((state_q == ST_WAIT) && raster_ack_i) begin
                req_if.done = w_owner_oh;
            end
            // Rejected ops report through the GAP cycle, never having issued.
            if ((state_q == ST_GAP) && inv_q) begin
                req_if.done = w_owner_oh;
                req_if.err  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        op_d    = op_q;
        owner_d = owner_q;
        inv_d   = inv_q;
        coord_d = coord_q;
        wd_d    = wd_q;
        if (w_gnt_valid) begin
            op_d    = w_sel_op;
            owner_d = w_gnt_idx;
            inv_d   = !op_is_valid(w_sel_op);
            coord_d = req_if.req_coord[w_gnt_idx];
        end
        if (state_q == ST_ISSUE) begin
            wd_d = '0;
        end else if ((state_q == ST_WAIT) && (wd_q != C_WD_MAX)) begin
            wd_d = wd_q + TIMEOUT_WIDTH'(1);
        end
        // Set on the cycle the counter first saturates; that beats a clear.
        if ((wd_d == C_WD_MAX) && (wd_q != C_WD_MAX)) begin
            tout_d = 1'b1;
        end else if (clr_timeout_i) begin
            tout_d = 1'b0;
        end else begin
            tout_d = tout_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q    <= 3'd0;
            owner_q <= 1'b0;
            inv_q   <= 1'b0;
            coord_q <= '0;
            wd_q    <= '0;
            tout_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            owner_q <= owner_d;
            inv_q   <= inv_d;
            coord_q <= coord_d;
            wd_q    <= wd_d;
            tout_q  <= tout_d;
        end
    end

    assign dest_pixel0_x_o = coord_q[0];
    assign dest_pixel0_y_o = coord_q[1];
    assign dest_pixel1_x_o = coord_q[2];
    assign dest_pixel1_y_o = coord_q[3];
    assign dest_pixel2_x_o = coord_q[4];
    assign dest_pixel2_y_o = coord_q[5];
    assign timeout_o       = tout_q;

endmodule : gfx_raster_sched
`default_nettype wire

// File: tb/tb_gfx_raster_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfx_raster_sched
// Description : Directed, table-driven bench for the raster command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_raster_sched;
    import gfx_raster_sched_pkg::*;

    localparam int CW = 32;
    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_PT   = 4'b1000;
    localparam logic [3:0] S_LN   = 4'b0100;
    localparam logic [3:0] S_RC   = 4'b0010;
    localparam logic [3:0] S_TR   = 4'b0001;

    logic clk = 1'b0;
    logic rst;
    logic busy, pw, rw, lw, tw, ack, tout, clr;
    logic signed [CW-1:0] d0x, d0y, d1x, d1y, d2x, d2y;

    always #5 clk = ~clk;

    gfx_raster_sched_if #(.CW(CW)) rif ();

    gfx_raster_sched #(
        .POINT_WIDTH    (16),
        .SUBPIXEL_WIDTH (16),
        .TIMEOUT_WIDTH  (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_if           (rif),
        .busy_o           (busy),
        .point_write_o    (pw),
        .rect_write_o     (rw),
        .line_write_o     (lw),
        .triangle_write_o (tw),
        .dest_pixel0_x_o  (d0x),
        .dest_pixel0_y_o  (d0y),
        .dest_pixel1_x_o  (d1x),
        .dest_pixel1_y_o  (d1y),
        .dest_pixel2_x_o  (d2x),
        .dest_pixel2_y_o  (d2y),
        .raster_ack_i     (ack),
        .timeout_o        (tout),
        .clr_timeout_i    (clr)
    );

    int tests = 0;
    int fails = 0;

    coord_t c0[6];
    coord_t c1[6];

    typedef struct {
        logic [1:0]  valid;
        logic [2:0]  op0;
        logic [2:0]  op1;
        logic        ack;
        logic        chk_c;
        logic [10:0] eo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {rif.req_ready, rif.done, rif.err, busy, pw, lw, rw, tw, tout};
    endfunction

    function automatic logic [10:0] mk(input logic [1:0] r, input logic [1:0] d, input logic e,
                                       input logic b, input logic [3:0] s, input logic t);
        return {r, d, e, b, s, t};
    endfunction

    function automatic logic [191:0] dest_all();
        return {d0x, d0y, d1x, d1y, d2x, d2y};
    endfunction

    function automatic logic [191:0] pack6(input coord_t a[6]);
        return {a[0], a[1], a[2], a[3], a[4], a[5]};
    endfunction

    function automatic void add(input logic [1:0] v, input logic [2:0] o0, input logic [2:0] o1,
                                input logic a, input logic cc, input logic [10:0] eo);
        vec_t x;
        x.valid = v; x.op0 = o0; x.op1 = o1; x.ack = a; x.chk_c = cc; x.eo = eo;
        vecs.push_back(x);
    endfunction

    task automatic drive(input logic [1:0] v, input logic [2:0] o0, input logic [2:0] o1,
                         input logic a, input logic c);
        rif.req_valid  = v;
        rif.req_op[0]  = o0;
        rif.req_op[1]  = o1;
        ack            = a;
        clr            = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset outs", {181'd0, outs()}, 192'd0);
        chk("reset coords", dest_all(), 192'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int p0[6];
        int p1[6];
        p0 = '{10, 20, 30, 40, 5, 6};
        p1 = '{-3, 7, 100, 200, 300, 400};
        for (int k = 0; k < 6; k++) begin
            c0[k] = coord_t'(p0[k] * 65536);
            c1[k] = coord_t'(p1[k] * 65536 + 32768);
            rif.req_coord[0][k] = c0[k];
            rif.req_coord[1][k] = c1[k];
        end

        // Single rect from port 0: grant c0, strobe c2, ack c9, idle c11.
        add(2'b01, 3'd2, 3'd0, 1'b0, 1'b0, mk(2'b01, 2'b00, 0, 0, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b1, mk(2'b00, 2'b00, 0, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b1, mk(2'b00, 2'b00, 0, 1, S_RC,   0));
        for (int k = 3; k <= 8; k++)
            add(2'b00, 3'd0, 3'd0, 1'b0, 1'b1, mk(2'b00, 2'b00, 0, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b1, 1'b1, mk(2'b00, 2'b01, 0, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b1, mk(2'b00, 2'b00, 0, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b1, mk(2'b00, 2'b00, 0, 0, S_NONE, 0));
        // Invalid opcode 5 from port 1.
        add(2'b10, 3'd0, 3'd5, 1'b0, 1'b0, mk(2'b10, 2'b00, 0, 0, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, mk(2'b00, 2'b10, 1, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, mk(2'b00, 2'b00, 0, 0, S_NONE, 0));
        // Spurious acks in IDLE and on the ISSUE cycle of a point.
        add(2'b00, 3'd0, 3'd0, 1'b1, 1'b0, mk(2'b00, 2'b00, 0, 0, S_NONE, 0));
        add(2'b01, 3'd0, 3'd0, 1'b0, 1'b0, mk(2'b01, 2'b00, 0, 0, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, mk(2'b00, 2'b00, 0, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b1, 1'b0, mk(2'b00, 2'b00, 0, 1, S_PT,   0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, mk(2'b00, 2'b00, 0, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b1, 1'b0, mk(2'b00, 2'b01, 0, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, mk(2'b00, 2'b00, 0, 1, S_NONE, 0));
        add(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, mk(2'b00, 2'b00, 0, 0, S_NONE, 0));

        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].op0, vecs[i].op1, vecs[i].ack, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d", i), {181'd0, outs()}, {181'd0, vecs[i].eo});
            if (vecs[i].chk_c) chk($sformatf("vec%0d coords", i), dest_all(), pack6(c0));
            @(posedge clk);
            #1;
        end

        // Both ports valid continuously, ack three cycles after each strobe.
        begin
            int grants, dones, cnt, cd, owner, last_g, bad;
            grants = 0; dones = 0; cnt = 0; cd = 0; owner = 0; last_g = -1; bad = 0;
            do_reset();
            drive(2'b11, OP_LINE, OP_TRI, 1'b0, 1'b0);
            while (dones < 4 && cnt < 200) begin
                @(negedge clk);
                cnt++;
                if (rif.req_ready != 2'b00) begin
                    if (busy) bad++;
                    chk($sformatf("alt grant%0d", grants), {190'd0, rif.req_ready},
                        (grants % 2 == 0) ? 192'd1 : 192'd2);
                    if (last_g >= 0) chk("alt interval", 192'(cnt - last_g), 192'd7);
                    last_g = cnt;
                    owner  = int'(rif.req_ready[1]);
                    grants++;
                end
                if ({pw, lw, rw, tw} != S_NONE) begin
                    chk($sformatf("alt strobe%0d", grants), {188'd0, pw, lw, rw, tw},
                        {188'd0, (owner == 1) ? S_TR : S_LN});
                    cd = 3;
                end
                if (rif.done != 2'b00) begin
                    chk($sformatf("alt done%0d", dones), {189'd0, rif.done, rif.err},
                        (owner == 1) ? 192'b100 : 192'b010);
                    dones++;
                end
                @(posedge clk);
                #1;
                ack = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) ack = 1'b1;
                end
                if (dones == 4) rif.req_valid = 2'b00;
            end
            chk("alt done count", 192'(dones), 192'd4);
            chk("alt grant while busy", 192'(bad), 192'd0);
        end

        // Watchdog: line from port 0 with a late ack; clear coincides with set.
        @(posedge clk);
        #1 drive(2'b01, OP_LINE, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("wd grant", {190'd0, rif.req_ready}, 192'd1);
        for (int c = 1; c <= 29; c++) begin
            @(posedge clk);
            #1 drive(2'b00, 3'd0, 3'd0, c == 26, (c == 17) || (c == 28));
            @(negedge clk);
            if (c == 2)  chk("wd strobe", {188'd0, pw, lw, rw, tw}, {188'd0, S_LN});
            if (c == 17) chk("wd tout before", {191'd0, tout}, 192'd0);
            if (c == 18) chk("wd tout set", {191'd0, tout}, 192'd1);
            if (c == 25) chk("wd still waiting", {190'd0, busy, tout}, 192'b11);
            if (c == 26) chk("wd late done", {189'd0, rif.done, rif.err}, 192'b010);
            if (c == 28) chk("wd sticky", {190'd0, busy, tout}, 192'b01);
            if (c == 29) chk("wd cleared", {191'd0, tout}, 192'd0);
        end

        // Reset in WAIT of a line, then a triangle from port 0.
        @(posedge clk);
        #1 drive(2'b01, OP_LINE, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst line grant", {190'd0, rif.req_ready}, 192'd1);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            rst = (c == 4);
            drive((c == 6) ? 2'b01 : 2'b00, OP_TRI, 3'd0, (c == 4) || (c == 10), 1'b0);
            @(negedge clk);
            if (c == 4)  chk("rst drops done", {186'd0, rif.done, pw, lw, rw, tw}, 192'd0);
            if (c == 5)  chk("rst outs idle", {181'd0, outs()}, 192'd0);
            if (c == 5)  chk("rst coords", dest_all(), 192'd0);
            if (c == 6)  chk("tri grant", {190'd0, rif.req_ready}, 192'd1);
            if (c == 7)  chk("tri coords", dest_all(), pack6(c0));
            if (c == 8)  chk("tri strobe", {188'd0, pw, lw, rw, tw}, {188'd0, S_TR});
            if (c == 10) chk("tri done", {189'd0, rif.done, rif.err}, 192'b010);
            if (c == 12) chk("tri idle", {191'd0, busy}, 192'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_gfx_raster_sched
`default_nettype wire
